// File: rtl/mem_stage_lsu_if.sv
// EX/MEM-to-MEM/WB bus for the MEM stage: upstream entry fields, branch/stall
// feedback and the MEM/WB pipeline register outputs.
interface mem_stage_lsu_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  valid_in;
    logic                  flush;
    logic [1:0]            wb_ctl_in;
    logic                  branch;
    logic                  zero;
    logic                  memread;
    logic                  memwrite;
    logic [2:0]            funct3;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       rdata2;
    logic [REG_ADDR_W-1:0] rd_in;

    logic                  pcsrc;
    logic                  stall;
    logic                  misaligned;
    logic                  wb_valid;
    logic                  wb_regwrite;
    logic                  wb_memtoreg;
    logic [XLEN-1:0]       wb_read_data;
    logic [XLEN-1:0]       wb_alu_result;
    logic [REG_ADDR_W-1:0] wb_rd;

    modport master (
        output valid_in, flush, wb_ctl_in, branch, zero, memread, memwrite,
               funct3, alu_result, rdata2, rd_in,
        input  pcsrc, stall, misaligned, wb_valid, wb_regwrite, wb_memtoreg,
               wb_read_data, wb_alu_result, wb_rd
    );

    modport slave (
        input  valid_in, flush, wb_ctl_in, branch, zero, memread, memwrite,
               funct3, alu_result, rdata2, rd_in,
        output pcsrc, stall, misaligned, wb_valid, wb_regwrite, wb_memtoreg,
               wb_read_data, wb_alu_result, wb_rd
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM stage: branch resolve, little-endian data memory with wait states, MEM/WB register.
// Define MEM_PERF_CNT_EN to add the perf_mem_ops / perf_stall_cycles counters.
//
// state  | meaning
// S_IDLE | no access in flight; single-cycle accesses complete here
// S_WAIT | multi-cycle access counting down wait states, upstream stalled
module mem_stage_lsu #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LATENCY = 1,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_stage_lsu_if.slave       bus
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0]          perf_mem_ops,
    output logic [31:0]          perf_stall_cycles
`endif
);
    localparam int ADDR_W   = $clog2(DEPTH_WORDS);
    localparam int NB       = XLEN / 8;
    localparam int CNT_W    = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
    localparam int CNT_INIT = (MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_INIT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0]       mem_q [DEPTH_WORDS];

    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_regwrite_q, wb_regwrite_d;
    logic                  wb_memtoreg_q, wb_memtoreg_d;
    logic [XLEN-1:0]       wb_read_data_q, wb_read_data_d;
    logic [XLEN-1:0]       wb_alu_result_q, wb_alu_result_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic                  misaligned_q, misaligned_d;

    logic                  memop;
    logic [ADDR_W-1:0]     word_idx;
    logic [1:0]            lane;
    logic                  acc_byte, acc_half, aligned;
    logic [XLEN-1:0]       rd_word, ld_data, st_data, wr_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [NB-1:0]         be;
    logic                  stall_c, complete, mem_we;

    // Address bits above the array wrap; they are intentionally not decoded.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.alu_result[XLEN-1:ADDR_W+2];

    always_comb begin
        memop    = bus.valid_in & (bus.memread | bus.memwrite) & ~bus.flush;
        word_idx = bus.alu_result[ADDR_W+1:2];
        lane     = bus.alu_result[1:0];

        // Loads fold funct3[2] (unsigned) into the size; stores treat 1xx as word.
        if (bus.memwrite) begin
            acc_byte = (bus.funct3 == 3'b000);
            acc_half = (bus.funct3 == 3'b001);
        end else begin
            acc_byte = (bus.funct3[1:0] == 2'b00);
            acc_half = (bus.funct3[1:0] == 2'b01);
        end
        aligned = acc_byte | (acc_half & ~lane[0]) |
                  (~acc_byte & ~acc_half & (lane == 2'b00));
    end

    always_comb begin
        rd_word = mem_q[word_idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (bus.funct3)
            3'b000:  ld_data = {{(XLEN-8){rd_byte[7]}}, rd_byte};
            3'b001:  ld_data = {{(XLEN-16){rd_half[15]}}, rd_half};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, rd_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, rd_half};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        if (acc_byte) begin
            be      = NB'(1) << lane;
            st_data = {NB{bus.rdata2[7:0]}};
        end else if (acc_half) begin
            be      = lane[1] ? NB'(4'b1100) : NB'(4'b0011);
            st_data = {(NB/2){bus.rdata2[15:0]}};
        end else begin
            be      = '1;
            st_data = bus.rdata2;
        end
        for (int i = 0; i < NB; i++) begin
            wr_word[8*i +: 8] = be[i] ? st_data[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_c  = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (memop & aligned) begin
                    if (MEM_LATENCY == 1) begin
                        complete = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = CNT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Flush (or a withdrawn entry) aborts without touching memory.
                if (!(memop & aligned)) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        mem_we = complete & bus.memwrite;
    end

    always_comb begin
        wb_valid_d      = 1'b0;
        wb_regwrite_d   = 1'b0;
        wb_memtoreg_d   = 1'b0;
        wb_read_data_d  = '0;
        wb_alu_result_d = '0;
        wb_rd_d         = '0;
        misaligned_d    = memop & ~aligned;
        if (misaligned_d) begin
            wb_valid_d      = 1'b1;
            wb_memtoreg_d   = bus.wb_ctl_in[0];
            wb_alu_result_d = bus.alu_result;
            wb_rd_d         = bus.rd_in;
        end else if (complete |
                     ((state_q == S_IDLE) & bus.valid_in & ~bus.flush &
                      ~(bus.memread | bus.memwrite))) begin
            wb_valid_d      = 1'b1;
            wb_regwrite_d   = bus.wb_ctl_in[1];
            wb_memtoreg_d   = bus.wb_ctl_in[0];
            wb_read_data_d  = (complete & bus.memread) ? ld_data : '0;
            wb_alu_result_d = bus.alu_result;
            wb_rd_d         = bus.rd_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            wb_valid_q      <= 1'b0;
            wb_regwrite_q   <= 1'b0;
            wb_memtoreg_q   <= 1'b0;
            wb_read_data_q  <= '0;
            wb_alu_result_q <= '0;
            wb_rd_q         <= '0;
            misaligned_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            wb_valid_q      <= wb_valid_d;
            wb_regwrite_q   <= wb_regwrite_d;
            wb_memtoreg_q   <= wb_memtoreg_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_rd_q         <= wb_rd_d;
            misaligned_q    <= misaligned_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[word_idx] <= wr_word;
        end
    end

`ifdef MEM_PERF_CNT_EN
    logic [31:0] perf_mem_ops_q, perf_mem_ops_d;
    logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;

    always_comb begin
        perf_mem_ops_d      = perf_mem_ops_q + {31'd0, complete};
        perf_stall_cycles_d = perf_stall_cycles_q + {31'd0, stall_c};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_mem_ops_q      <= '0;
            perf_stall_cycles_q <= '0;
        end else begin
            perf_mem_ops_q      <= perf_mem_ops_d;
            perf_stall_cycles_q <= perf_stall_cycles_d;
        end
    end

    assign perf_mem_ops      = perf_mem_ops_q;
    assign perf_stall_cycles = perf_stall_cycles_q;
`endif

    assign bus.pcsrc         = bus.valid_in & bus.branch & bus.zero & ~bus.flush;
    assign bus.stall         = stall_c;
    assign bus.misaligned    = misaligned_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_regwrite   = wb_regwrite_q;
    assign bus.wb_memtoreg   = wb_memtoreg_q;
    assign bus.wb_read_data  = wb_read_data_q;
    assign bus.wb_alu_result = wb_alu_result_q;
    assign bus.wb_rd         = wb_rd_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: one instance with single-cycle memory,
// one with four-cycle memory, sharing the data fields and with separate valids.
module tb_mem_stage_lsu;
    logic clock;
    logic reset;

    logic        v1, v4, s_flush, s_branch, s_zero, s_memread, s_memwrite;
    logic [1:0]  s_ctl;
    logic [2:0]  s_f3;
    logic [31:0] s_addr, s_wdata;
    logic [4:0]  s_rd;

    int n_checks = 0;
    int n_fail   = 0;
    int stall1_hits = 0;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        logic [31:0] alu;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    mem_stage_lsu_if #(.XLEN(32), .REG_ADDR_W(5)) if1 ();
    mem_stage_lsu_if #(.XLEN(32), .REG_ADDR_W(5)) if4 ();

`ifdef MEM_PERF_CNT_EN
    logic [31:0] perf_ops1, perf_stl1, perf_ops4, perf_stl4;
`endif

    mem_stage_lsu #(.XLEN(32), .DEPTH_WORDS(256), .MEM_LATENCY(1), .REG_ADDR_W(5)) u_lat1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1)
`ifdef MEM_PERF_CNT_EN
        , .perf_mem_ops (perf_ops1), .perf_stall_cycles (perf_stl1)
`endif
    );

    mem_stage_lsu #(.XLEN(32), .DEPTH_WORDS(256), .MEM_LATENCY(4), .REG_ADDR_W(5)) u_lat4 (
        .clock (clock),
        .reset (reset),
        .bus   (if4)
`ifdef MEM_PERF_CNT_EN
        , .perf_mem_ops (perf_ops4), .perf_stall_cycles (perf_stl4)
`endif
    );

    assign if1.valid_in   = v1;
    assign if4.valid_in   = v4;
    assign if1.flush      = s_flush;
    assign if4.flush      = s_flush;
    assign if1.branch     = s_branch;
    assign if4.branch     = s_branch;
    assign if1.zero       = s_zero;
    assign if4.zero       = s_zero;
    assign if1.memread    = s_memread;
    assign if4.memread    = s_memread;
    assign if1.memwrite   = s_memwrite;
    assign if4.memwrite   = s_memwrite;
    assign if1.wb_ctl_in  = s_ctl;
    assign if4.wb_ctl_in  = s_ctl;
    assign if1.funct3     = s_f3;
    assign if4.funct3     = s_f3;
    assign if1.alu_result = s_addr;
    assign if4.alu_result = s_addr;
    assign if1.rdata2     = s_wdata;
    assign if4.rdata2     = s_wdata;
    assign if1.rd_in      = s_rd;
    assign if4.rd_in      = s_rd;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (!reset && if1.wb_valid) begin
            if (q1.size() == 0) begin
                check_eq("l1_unexpected_wb", 32'(if1.wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check_eq("l1_wb_rd", 32'(if1.wb_rd), 32'(e.rd));
                check_eq("l1_wb_regwrite", 32'(if1.wb_regwrite), 32'(e.rw));
                check_eq("l1_wb_read_data", if1.wb_read_data, e.data);
                check_eq("l1_wb_alu_result", if1.wb_alu_result, e.alu);
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (!reset && if4.wb_valid) begin
            if (q4.size() == 0) begin
                check_eq("l4_unexpected_wb", 32'(if4.wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check_eq("l4_wb_rd", 32'(if4.wb_rd), 32'(e.rd));
                check_eq("l4_wb_regwrite", 32'(if4.wb_regwrite), 32'(e.rw));
                check_eq("l4_wb_read_data", if4.wb_read_data, e.data);
                check_eq("l4_wb_alu_result", if4.wb_alu_result, e.alu);
            end
        end
    end

    always @(negedge clock) begin
        #3;
        if (!reset && if1.stall) stall1_hits++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_in(input logic rdop, input logic wrop, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [1:0] ctl);
        s_memread  = rdop;
        s_memwrite = wrop;
        s_f3       = f3;
        s_addr     = addr;
        s_wdata    = wd;
        s_rd       = rd;
        s_ctl      = ctl;
    endtask

    task automatic issue1(input logic rdop, input logic wrop, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [1:0] ctl,
                          input logic erw, input logic [31:0] edata);
        set_in(rdop, wrop, f3, addr, wd, rd, ctl);
        v1 = 1'b1;
        q1.push_back('{rd, erw, edata, addr});
        #1 check_eq("l1_stall_low", 32'(if1.stall), 32'd0);
        @(negedge clock);
    endtask

    // Issues an access to the four-cycle instance and counts its stall cycles.
    task automatic issue4(input logic rdop, input logic wrop, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [1:0] ctl,
                          input logic erw, input logic [31:0] edata);
        int n;
        set_in(rdop, wrop, f3, addr, wd, rd, ctl);
        v4 = 1'b1;
        q4.push_back('{rd, erw, edata, addr});
        n = 0;
        #1;
        while (if4.stall && n < 10) begin
            if (n > 0) check_eq("l4_bubble_valid", 32'(if4.wb_valid), 32'd0);
            n++;
            @(negedge clock);
            #1;
        end
        check_eq("l4_stall_cycles", 32'(n), 32'd3);
        check_eq("l4_not_early", 32'(if4.wb_valid), 32'd0);
        @(negedge clock);
        v4 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        v1 = 1'b0; v4 = 1'b0; s_flush = 1'b0; s_branch = 1'b0; s_zero = 1'b0;
        set_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 2'b00);
        repeat (2) @(negedge clock);
        #1;
        check_eq("rst_wb_valid", 32'(if1.wb_valid), 32'd0);
        check_eq("rst_wb_read_data", if1.wb_read_data, 32'd0);
        check_eq("rst_misaligned", 32'(if1.misaligned), 32'd0);
        check_eq("rst_stall4", 32'(if4.stall), 32'd0);
        check_eq("rst_pcsrc", 32'(if1.pcsrc), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Single-cycle instance: word, sub-word and misaligned traffic.
        issue1(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 2'b00, 1'b0, 32'h0);
        issue1(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd1, 2'b11, 1'b1, 32'hDEADBEEF);
        issue1(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 5'd2, 2'b11, 1'b1, 32'hFFFFFFDE);
        issue1(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 5'd3, 2'b11, 1'b1, 32'h000000DE);
        issue1(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 5'd4, 2'b11, 1'b1, 32'hFFFFDEAD);
        issue1(1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 5'd5, 2'b11, 1'b1, 32'h0000BEEF);
        issue1(1'b0, 1'b1, 3'b000, 32'h11, 32'h55, 5'd0, 2'b00, 1'b0, 32'h0);
        issue1(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd6, 2'b11, 1'b1, 32'hDEAD55EF);
        issue1(1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 5'd7, 2'b11, 1'b0, 32'h0);
        check_eq("misaligned_set", 32'(if1.misaligned), 32'd1);
        issue1(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd8, 2'b10, 1'b1, 32'h0);
        check_eq("misaligned_one_cycle", 32'(if1.misaligned), 32'd0);
        issue1(1'b0, 1'b1, 3'b001, 32'h11, 32'hAAAA, 5'd0, 2'b00, 1'b0, 32'h0);
        issue1(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd9, 2'b11, 1'b1, 32'hDEAD55EF);
        issue1(1'b0, 1'b1, 3'b010, 32'h414, 32'h12345678, 5'd0, 2'b00, 1'b0, 32'h0);
        issue1(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 5'd10, 2'b11, 1'b1, 32'h12345678);
        issue1(1'b1, 1'b0, 3'b010, 32'hFFFFFC10, 32'h0, 5'd11, 2'b11, 1'b1, 32'hDEAD55EF);

        // Branch resolve, then the same entry squashed.
        s_branch = 1'b1; s_zero = 1'b1;
        set_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd12, 2'b00);
        v1 = 1'b1;
        q1.push_back('{5'd12, 1'b0, 32'h0, 32'h0});
        #1 check_eq("pcsrc_taken", 32'(if1.pcsrc), 32'd1);
        @(negedge clock);
        s_flush = 1'b1;
        #1 check_eq("pcsrc_flushed", 32'(if1.pcsrc), 32'd0);
        @(negedge clock);
        s_flush = 1'b0; s_branch = 1'b0; s_zero = 1'b0; v1 = 1'b0;
        repeat (2) @(negedge clock);

        // Four-cycle instance: stall length, flush mid-wait.
        issue4(1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 5'd0, 2'b00, 1'b0, 32'h0);
        issue4(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd13, 2'b11, 1'b1, 32'hCAFEF00D);
        set_in(1'b0, 1'b1, 3'b010, 32'h20, 32'h11112222, 5'd0, 2'b00);
        v4 = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        #1 check_eq("flush_pre_stall", 32'(if4.stall), 32'd1);
        s_flush = 1'b1;
        #1 check_eq("flush_stall_drop", 32'(if4.stall), 32'd0);
        @(negedge clock);
        s_flush = 1'b0; v4 = 1'b0;
        @(negedge clock);
        issue4(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd14, 2'b11, 1'b1, 32'hCAFEF00D);

        // Asynchronous reset while the four-cycle instance is mid-wait.
        set_in(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd15, 2'b11);
        v1 = 1'b1; v4 = 1'b1;
        q1.push_back('{5'd15, 1'b1, 32'h0, 32'h20});
        @(negedge clock);
        q1.push_back('{5'd15, 1'b1, 32'h0, 32'h20});
        @(posedge clock);
        #2;
        check_eq("rst_pre_wb_valid", 32'(if1.wb_valid), 32'd1);
        check_eq("rst_pre_stall", 32'(if4.stall), 32'd1);
        reset = 1'b1;
        v1 = 1'b0;
        #1;
        check_eq("rst_async_wb_valid", 32'(if1.wb_valid), 32'd0);
        check_eq("rst_async_wb_rd", 32'(if1.wb_rd), 32'd0);
        check_eq("rst_async_wb_regwrite", 32'(if1.wb_regwrite), 32'd0);
        check_eq("rst_async_wb_alu", if1.wb_alu_result, 32'd0);
        check_eq("rst_async_misaligned4", 32'(if4.misaligned), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        issue4(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd16, 2'b11, 1'b1, 32'h0);
        issue1(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd17, 2'b11, 1'b1, 32'h0);
        v1 = 1'b0;
        repeat (3) @(negedge clock);

        check_eq("l1_queue_drained", 32'(q1.size()), 32'd0);
        check_eq("l4_queue_drained", 32'(q4.size()), 32'd0);
        check_eq("l1_never_stalled", 32'(stall1_hits), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
